// File: rtl/lsu_mem_if.sv
// lsu_mem_if: req/ack data-memory bus; the LSU is the master and the memory is the slave.
// mem_req is held until mem_ack, and mem_rdata is valid in the same cycle as mem_ack.
interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_mem.sv
// lsu_mem: M-stage load/store unit over a req/ack memory; LSU_TIMEOUT_EN adds a REQ timeout abort.
// Latency: IDLE + n REQ + DONE cycles; StallMemM holds the pipeline until DONE.
module lsu_mem #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallMemM,
    output logic        MisalignM,
    output logic        BusErrM,
    lsu_mem_if.master   mem
);

    if (2 ** CNT_W <= TIMEOUT) begin : g_bad_cfg
        $error("lsu_mem: CNT_W too narrow for TIMEOUT");
    end

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_be_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [31:0] rdata_q;

    logic        access;
    logic        aligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    assign access = MemWriteM | MemReadM;

    // funct3[1:0]: 00 byte, 01 half, anything else is a word access.
    always_comb begin
        aligned = 1'b1;
        be_d    = 4'b1111;
        wdata_d = 32'h0;
        case (funct3M[1:0])
            2'b00: begin
                aligned = 1'b1;
                be_d    = 4'b0001 << ALUResultM[1:0];
                wdata_d = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                aligned = ~ALUResultM[0];
                be_d    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{WriteDataM[15:0]}};
            end
            default: begin
                aligned = (ALUResultM[1:0] == 2'b00);
                be_d    = 4'b1111;
                wdata_d = WriteDataM;
            end
        endcase
        if (!MemWriteM) begin
            be_d    = 4'b1111;
            wdata_d = 32'h0;
        end
    end

    function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] lo,
                                             input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  ext_load = {{24{b[7]}}, b};
            3'b100:  ext_load = {24'h0, b};
            3'b001:  ext_load = {{16{h[15]}}, h};
            3'b101:  ext_load = {16'h0, h};
            default: ext_load = w;
        endcase
    endfunction

`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             buserr_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            f3_q        <= 3'h0;
            lo_q        <= 2'h0;
            rdata_q     <= 32'h0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
            buserr_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (access && aligned) begin
                        mem_addr_q  <= {ALUResultM[31:2], 2'b00};
                        mem_we_q    <= MemWriteM;
                        mem_be_q    <= be_d;
                        mem_wdata_q <= wdata_d;
                        f3_q        <= funct3M;
                        lo_q        <= ALUResultM[1:0];
                        mem_req_q   <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_be_q  <= 4'h0;
                        if (!mem_we_q) begin
                            rdata_q <= ext_load(mem.mem_rdata, lo_q, f3_q);
                        end
                        state_q   <= DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Abandon the access; a timed-out store counts as not performed.
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_be_q  <= 4'h0;
                        rdata_q   <= 32'h0;
                        buserr_q  <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    rdata_q  <= 32'h0;
`ifdef LSU_TIMEOUT_EN
                    buserr_q <= 1'b0;
`endif
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_be    = mem_be_q;

    assign ReadDataM = rdata_q;
    // Reset gating keeps the hazard unit released while reset is held.
    assign StallMemM = reset & ((state_q == REQ) | ((state_q == IDLE) & access & aligned));
    assign MisalignM = reset & (state_q == IDLE) & access & ~aligned;

`ifdef LSU_TIMEOUT_EN
    assign BusErrM = buserr_q;
`else
    assign BusErrM = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: scoreboard bench for lsu_mem; expected bus fields and load data are queued at issue
// and compared when the DUT raises the request and reaches DONE.
module tb_lsu_mem;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWriteM = 1'b0;
    logic        MemReadM = 1'b0;
    logic [2:0]  funct3M = 3'b010;
    logic [31:0] ALUResultM = 32'h0;
    logic [31:0] WriteDataM = 32'h0;
    logic [31:0] ReadDataM;
    logic        StallMemM;
    logic        MisalignM;
    logic        BusErrM;

    lsu_mem_if mem_bus ();

    lsu_mem #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallMemM  (StallMemM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_access(input string name, input logic wr, input logic rd,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int ack_on,
                              input logic [31:0] rdata, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                              input int exp_stall);
        exp_t e;
        exp_t f;
        int   stalls;
        int   reqc;
        int   cyc;
        bit   done;
        e.addr  = {addr[31:2], 2'b00};
        e.we    = wr;
        e.be    = exp_be;
        e.wdata = exp_wd;
        e.rd    = exp_rd;
        sb_q.push_back(e);
        @(negedge clk);
        MemWriteM = wr;
        MemReadM  = rd;
        funct3M   = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        mem_bus.mem_rdata = rdata;
        stalls = 0;
        reqc   = 0;
        cyc    = 0;
        done   = 1'b0;
        while (!done && cyc < 300) begin
            #1;
            if (StallMemM) stalls++;
            if (mem_bus.mem_req) begin
                reqc++;
                if (reqc == 1) begin
                    f = sb_q[0];
                    check_eq({name, ".addr"}, mem_bus.mem_addr, f.addr);
                    check_eq({name, ".we"}, {31'h0, mem_bus.mem_we}, {31'h0, f.we});
                    check_eq({name, ".be"}, {28'h0, mem_bus.mem_be}, {28'h0, f.be});
                    if (f.we) check_eq({name, ".wdata"}, mem_bus.mem_wdata, f.wdata);
                    check_eq({name, ".rd_req"}, ReadDataM, 32'h0);
                end
                mem_bus.mem_ack = (reqc == ack_on);
            end else if (cyc > 0) begin
                done = 1'b1;
                mem_bus.mem_ack = 1'b0;
                f = sb_q.pop_front();
                check_eq({name, ".rdata"}, ReadDataM, f.rd);
                check_eq({name, ".buserr"}, {31'h0, BusErrM}, 32'h0);
                MemWriteM = 1'b0;
                MemReadM  = 1'b0;
            end
            cyc++;
            if (!done) @(negedge clk);
        end
        check_eq({name, ".done"}, {31'h0, done}, 32'h1);
        check_eq({name, ".stalls"}, stalls, exp_stall);
        @(negedge clk);
        #1;
        check_eq({name, ".rd_clr"}, ReadDataM, 32'h0);
    endtask

    task automatic run_misalign(input string name, input logic wr, input logic rd,
                                input logic [2:0] f3, input logic [31:0] addr);
        @(negedge clk);
        MemWriteM  = wr;
        MemReadM   = rd;
        funct3M    = f3;
        ALUResultM = addr;
        #1;
        check_eq({name, ".mis"}, {31'h0, MisalignM}, 32'h1);
        check_eq({name, ".stall"}, {31'h0, StallMemM}, 32'h0);
        check_eq({name, ".rd"}, ReadDataM, 32'h0);
        @(negedge clk);
        #1;
        check_eq({name, ".req"}, {31'h0, mem_bus.mem_req}, 32'h0);
        MemWriteM = 1'b0;
        MemReadM  = 1'b0;
        #1;
        check_eq({name, ".mis_clr"}, {31'h0, MisalignM}, 32'h0);
        @(negedge clk);
        #1;
        check_eq({name, ".req2"}, {31'h0, mem_bus.mem_req}, 32'h0);
    endtask

    initial begin
        int reqc;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        #2;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst.req", {31'h0, mem_bus.mem_req}, 32'h0);
        check_eq("rst.we", {31'h0, mem_bus.mem_we}, 32'h0);
        check_eq("rst.be", {28'h0, mem_bus.mem_be}, 32'h0);
        check_eq("rst.addr", mem_bus.mem_addr, 32'h0);
        check_eq("rst.wdata", mem_bus.mem_wdata, 32'h0);
        check_eq("rst.rd", ReadDataM, 32'h0);
        check_eq("rst.stall", {31'h0, StallMemM}, 32'h0);
        check_eq("rst.mis", {31'h0, MisalignM}, 32'h0);
        check_eq("rst.buserr", {31'h0, BusErrM}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        //         name     wr    rd    f3      addr          wd            ack rdata         be       wdata         rd            stall
        run_access("lw100", 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0,        3, 32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEAD_BEEF, 4);
        run_access("lb103", 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0,        1, 32'h8012_3456, 4'b1111, 32'h0,        32'hFFFF_FF80, 2);
        run_access("lbu103",1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'h0,        1, 32'h8012_3456, 4'b1111, 32'h0,        32'h0000_0080, 2);
        run_access("lh102", 1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0,        2, 32'h8012_3456, 4'b1111, 32'h0,        32'hFFFF_8012, 3);
        run_access("lhu100",1'b0, 1'b1, 3'b101, 32'h0000_0100, 32'h0,        1, 32'h1234_F00D, 4'b1111, 32'h0,        32'h0000_F00D, 2);
        run_access("lh100", 1'b0, 1'b1, 3'b001, 32'h0000_0100, 32'h0,        1, 32'h1234_F00D, 4'b1111, 32'h0,        32'hFFFF_F00D, 2);
        run_access("lb101", 1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0,        1, 32'h1234_5678, 4'b1111, 32'h0,        32'h0000_0056, 2);
        run_access("sh202", 1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 2, 32'h5555_5555, 4'b1100, 32'hABCD_ABCD, 32'h0,         3);
        run_access("sb201", 1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'h1234_56A5, 1, 32'h5555_5555, 4'b0010, 32'hA5A5_A5A5, 32'h0,         2);
        run_access("sw300", 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 4, 32'h0,         4'b1111, 32'hCAFE_F00D, 32'h0,         5);
        run_access("wr_rd", 1'b1, 1'b1, 3'b010, 32'h0000_0304, 32'h0BAD_C0DE, 1, 32'h7777_7777, 4'b1111, 32'h0BAD_C0DE, 32'h0,         2);

        run_misalign("mis_lw101", 1'b0, 1'b1, 3'b010, 32'h0000_0101);
        run_misalign("mis_lh103", 1'b0, 1'b1, 3'b001, 32'h0000_0103);
        run_misalign("mis_sw302", 1'b1, 1'b0, 3'b010, 32'h0000_0302);

        // Request with no ack.
        @(negedge clk);
        MemReadM   = 1'b1;
        funct3M    = 3'b010;
        ALUResultM = 32'h0000_0400;
        mem_bus.mem_ack = 1'b0;
`ifdef LSU_TIMEOUT_EN
        reqc = 0;
        @(negedge clk);
        #1;
        while (mem_bus.mem_req && reqc < 100) begin
            reqc++;
            @(negedge clk);
            #1;
        end
        check_eq("to.req_cycles", reqc, 16);
        check_eq("to.buserr", {31'h0, BusErrM}, 32'h1);
        check_eq("to.rd", ReadDataM, 32'h0);
        check_eq("to.stall", {31'h0, StallMemM}, 32'h0);
        MemReadM = 1'b0;
        @(negedge clk);
        #1;
        check_eq("to.buserr_clr", {31'h0, BusErrM}, 32'h0);
`else
        reqc = 0;
        repeat (100) @(negedge clk);
        #1;
        check_eq("nto.req_held", {31'h0, mem_bus.mem_req}, 32'h1);
        check_eq("nto.stall", {31'h0, StallMemM}, 32'h1);
        check_eq("nto.buserr", {31'h0, BusErrM}, 32'h0);
        reset = 1'b0;
        #1;
        check_eq("nto.rst_req", {31'h0, mem_bus.mem_req}, 32'h0);
        MemReadM = 1'b0;
        @(negedge clk);
        reset = 1'b1;
`endif

        // Reset asserted mid-REQ, away from any clock edge.
        @(negedge clk);
        MemReadM   = 1'b1;
        funct3M    = 3'b010;
        ALUResultM = 32'h0000_0500;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("mrst.req_before", {31'h0, mem_bus.mem_req}, 32'h1);
        reset = 1'b0;
        #1;
        check_eq("mrst.req", {31'h0, mem_bus.mem_req}, 32'h0);
        check_eq("mrst.stall", {31'h0, StallMemM}, 32'h0);
        check_eq("mrst.rd", ReadDataM, 32'h0);
        MemReadM = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_access("lw0", 1'b0, 1'b1, 3'b010, 32'h0, 32'h0, 1, 32'h0102_0304, 4'b1111, 32'h0, 32'h0102_0304, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem.md
Name: lsu_mem

Overview:
- Memory-stage load/store unit between the pipelined core's M stage and a data memory with variable latency and a req/ack handshake.
- Takes the M-stage address and store data, and drives byte enables and replicated write data.
- Sign- or zero-extends load data.
- Raises a stall to the hazard unit until the access completes.
- Replaces the core's fixed single-cycle data-memory assumption.

Parameters:
- TIMEOUT, 16, maximum cycles in REQ waiting for mem_ack before the access aborts (only used when LSU_TIMEOUT_EN is defined).
- CNT_W, 5, width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- MemWriteM  in  1  M-stage store
- MemReadM  in  1  M-stage load
- funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, right-aligned
- ReadDataM  out  32  extended load data, valid in DONE
- StallMemM  out  1  to hazard unit: hold F/D/E/M, bubble into W
- MisalignM  out  1  one-cycle pulse on a misaligned access
- BusErrM  out  1  one-cycle pulse on timeout (LSU_TIMEOUT_EN only)
- mem_req  out  1  request, held until ack
- mem_we  out  1  write strobe
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  access complete; mem_rdata valid in the same cycle
- mem_rdata  in  32  read word

Behaviour:
- Reset (async, reset==0):
  - state is IDLE.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, ReadDataM, MisalignM, BusErrM are all 0.
  - Wait counter is 0.
  - StallMemM is 0.
  - A reset during REQ drops mem_req immediately; the memory must tolerate an abandoned request.
- Access definition:
  - access = MemWriteM | MemReadM.
  - If both are set, the write wins and the read is ignored.
- Alignment:
  - W needs addr[1:0]==00.
  - H/HU needs addr[0]==0.
  - B is always aligned.
  - Any other funct3 is treated as W.
- Misaligned access, in IDLE:
  - No request is issued and StallMemM stays 0.
  - MisalignM is 1 for that cycle only (combinational).
  - ReadDataM is 0.
- FSM states:
  - IDLE:
    - StallMemM = access & aligned.
    - On an aligned access, at the clock edge, register mem_addr, mem_we, mem_be and mem_wdata, set mem_req=1, clear the counter, and go to REQ.
  - REQ:
    - StallMemM=1 and mem_req is held with stable address and data.
    - On mem_ack, capture mem_rdata, set mem_req=0, go to DONE.
    - Otherwise the counter increments.
  - DONE:
    - StallMemM=0 and mem_req=0.
    - ReadDataM = extension of the captured word.
    - The pipeline advances; the next state is always IDLE.
- Latency:
  - An ack in the first REQ cycle gives 2 stall cycles plus the DONE cycle, i.e. 3 cycles of M occupancy.
  - Each wait cycle adds 1.
- Store formatting:
  - SB: mem_wdata={4{WriteDataM[7:0]}}, mem_be=4'b0001<<addr[1:0].
  - SH: mem_wdata={2{WriteDataM[15:0]}}, mem_be = addr[1] ? 1100 : 0011.
  - SW: mem_be=1111.
  - Loads: mem_be=1111, mem_we=0.
- Load extension:
  - Select the byte or half by addr[1:0] of the latched address.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Outside DONE, ReadDataM is 0.
- mem_ack is ignored outside REQ.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - In REQ, when the counter reaches TIMEOUT without ack, drop mem_req and go to DONE.
  - In DONE, BusErrM=1 for one cycle and ReadDataM=0.
  - A store that times out is treated as not performed.
- LSU_TIMEOUT_EN undefined:
  - No counter logic; REQ waits indefinitely.
  - BusErrM is tied to 0.

Test Plan:
- LW at 0x100, ack asserted on the 3rd REQ cycle with rdata 0xDEADBEEF:
  - StallMemM high for 4 cycles.
  - DONE shows ReadDataM=0xDEADBEEF.
  - mem_addr=0x100, mem_be=1111.
- LB at 0x103, rdata 0x80123456: ReadDataM=0xFFFFFF80. LBU at the same address: 0x00000080.
- SH at 0x202, WriteDataM=0x0000ABCD:
  - mem_we=1, mem_wdata=0xABCDABCD, mem_be=1100.
  - No ReadDataM change (stays 0).
- LW at 0x101: MisalignM=1 for one cycle, mem_req never rises, StallMemM stays 0.
- LSU_TIMEOUT_EN with TIMEOUT=16, no ack:
  - mem_req falls after 16 REQ cycles.
  - BusErrM pulses in DONE and ReadDataM=0.
  - Without the macro, mem_req is still high after 100 cycles.
- reset driven low two cycles into REQ:
  - mem_req and StallMemM go to 0 immediately, without waiting for a clock edge.
  - After release, an LW at 0x0 completes normally.
